// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STAT bit
// positions and the TX/RX state encodings.
package uart_pkg;

    localparam logic [31:0] OFF_TXD  = 32'd0;
    localparam logic [31:0] OFF_RXD  = 32'd4;
    localparam logic [31:0] OFF_STAT = 32'd8;

    localparam int STAT_RX_VALID  = 0;
    localparam int STAT_TX_BUSY   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_TX_ERR    = 4;
    localparam int STAT_TX_DONE   = 5;
    localparam int STAT_RX_IE     = 8;
    localparam int STAT_TX_IE     = 9;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: rx synchronizer, start-bit qualification and LSB-first shifter.
// Each completed frame yields one byte_valid pulse with the byte and stop level.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       stop_ok
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIV / 2 - 1);

    rx_state_e        state, state_next;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             rx_s, fall, tick, shift_en, done;

    // sync_q[1:0] is the two-flop synchronizer; sync_q[2] only delays it for edge detection.
    assign rx_s = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 3'b111;
        else        sync_q <= {sync_q[1:0], rx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RX_IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (fall) state_next = RX_START;
            RX_START: if (tick) state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_cnt == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (tick) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // Start bit is probed at mid-bit; every later sample is a full bit time on.
    always_comb begin
        tick     = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        case (state)
            RX_START: tick = (cnt == CNT_MID);
            RX_DATA: begin
                tick     = (cnt == CNT_LAST);
                shift_en = tick;
            end
            RX_STOP: begin
                tick = (cnt == CNT_LAST);
                done = tick;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            stop_ok    <= 1'b0;
        end else begin
            byte_valid <= done;
            if (state == RX_IDLE || state_next != state || cnt == CNT_LAST)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (state == RX_IDLE)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)
                shift_q <= {rx_s, shift_q[7:1]};
            if (done) begin
                data    <= shift_q;
                stop_ok <= rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_mmio_port.sv
// Bus-side UART responder: TXD/RXD/STAT registers, 8N1 transmitter, flags and
// a level interrupt. Reads are combinational so loads complete in one cycle.
module uart_mmio_port
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV = 10416,
    parameter logic [31:0] BASE     = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        rx,
    output logic        tx
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic sel_txd, sel_rxd, sel_stat;
    logic txd_wr, rxd_rd, stat_wr;

    assign sel_txd  = (addr == BASE + OFF_TXD);
    assign sel_rxd  = (addr == BASE + OFF_RXD);
    assign sel_stat = (addr == BASE + OFF_STAT);
    assign txd_wr   = wr & sel_txd;
    assign rxd_rd   = rd & sel_rxd;
    assign stat_wr  = wr & sel_stat;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:10];

    // ---------------- transmitter ----------------
    tx_state_e        tx_state, tx_state_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_byte;
    logic             tx_tick, tx_busy, tx_accept, tx_done_set, tx_err_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (txd_wr) tx_state_next = TX_START;
            TX_START: if (tx_tick) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx          = 1'b1;
        tx_busy     = (tx_state != TX_IDLE);
        tx_tick     = tx_busy && (tx_cnt == CNT_LAST);
        tx_accept   = txd_wr && !tx_busy;
        tx_err_set  = txd_wr && tx_busy;
        tx_done_set = (tx_state == TX_STOP) && tx_tick;
        case (tx_state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_byte[tx_bit];
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else begin
            if (tx_accept)
                tx_byte <= wdata[7:0];
            if (!tx_busy || tx_tick)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + CNT_W'(1);
            if (!tx_busy)
                tx_bit <= '0;
            else if (tx_state == TX_DATA && tx_tick)
                tx_bit <= tx_bit + 3'd1;
        end
    end

    // ---------------- receiver ----------------
    logic [7:0] rx_byte;
    logic       rx_byte_valid, rx_stop_ok;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (rx_byte),
        .byte_valid (rx_byte_valid),
        .stop_ok    (rx_stop_ok)
    );

    // ---------------- flags and enables ----------------
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, tx_err, tx_done, rx_ie, tx_ie;

    // Hardware set terms are OR-ed after the clear term so a same-edge set beats W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            tx_err    <= 1'b0;
            tx_done   <= 1'b0;
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
        end else begin
            if (rx_byte_valid) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
            end else if (rxd_rd) begin
                rx_valid <= 1'b0;
            end
            overrun   <= (rx_byte_valid && rx_valid && !rxd_rd)
                         || (overrun && !(stat_wr && wdata[STAT_OVERRUN]));
            frame_err <= (rx_byte_valid && !rx_stop_ok)
                         || (frame_err && !(stat_wr && wdata[STAT_FRAME_ERR]));
            tx_err    <= tx_err_set  || (tx_err  && !(stat_wr && wdata[STAT_TX_ERR]));
            tx_done   <= tx_done_set || (tx_done && !(stat_wr && wdata[STAT_TX_DONE]));
            if (stat_wr) begin
                rx_ie <= wdata[STAT_RX_IE];
                tx_ie <= wdata[STAT_TX_IE];
            end
        end
    end

    logic [31:0] stat;

    always_comb begin
        stat                 = '0;
        stat[STAT_RX_VALID]  = rx_valid;
        stat[STAT_TX_BUSY]   = tx_busy;
        stat[STAT_FRAME_ERR] = frame_err;
        stat[STAT_OVERRUN]   = overrun;
        stat[STAT_TX_ERR]    = tx_err;
        stat[STAT_TX_DONE]   = tx_done;
        stat[STAT_RX_IE]     = rx_ie;
        stat[STAT_TX_IE]     = tx_ie;
    end

    // TXD is write-only and reads back as zero.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rxd)
                rdata = {24'd0, rx_data};
            else if (sel_stat)
                rdata = stat;
        end
    end

    assign irq = (rx_ie & rx_valid) | (tx_ie & tx_done);

endmodule

// File: tb/tb_uart_mmio_port.sv
// Self-checking bench for uart_mmio_port with BAUD_DIV=4: scoreboarded TX
// frames and RX bytes, STAT/irq behaviour, error flags and mid-frame reset.
module tb_uart_mmio_port;

    localparam int          BD   = 4;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] STAT = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        irq, rx, tx;

    int n_checks = 0;
    int n_pass   = 0;
    int tx_frames = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    uart_mmio_port #(
        .BAUD_DIV (BD),
        .BASE     (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [9:0]  f;
        logic [39:0] v;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) v[i] = f[i / BD];
        return v;
    endfunction

    // All bus tasks start and end just after a falling clock edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0; addr = '0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic send_tx(input logic [7:0] b);
        tx_exp_q.push_back(b);
        bus_write(TXD, {24'd0, b});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        rx_exp_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BD) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic read_rx_check(input string tag);
        logic [31:0] d;
        logic [7:0]  exp;
        exp = (rx_exp_q.size() > 0) ? rx_exp_q[$] : 8'hxx;
        rx_exp_q.delete();
        bus_read(RXD, d);
        check(tag, d, {24'd0, exp});
    endtask

    task automatic wait_tx_frames(input string tag, input int target);
        int n = 0;
        while (tx_frames < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx_frames, target);
        @(negedge clk);
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (irq !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, irq, 1'b1);
    endtask

    // TX monitor: captures 40 consecutive per-cycle samples from each start bit.
    initial begin : tx_monitor
        logic        prev_tx, active;
        int          slot;
        logic [39:0] vec;
        logic [7:0]  exp;
        prev_tx = 1'b1; active = 1'b0; slot = 0; vec = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                active  = 1'b0;
                prev_tx = 1'b1;
                tx_exp_q.delete();
            end else begin
                if (!active && prev_tx && tx === 1'b0) begin
                    active = 1'b1;
                    slot   = 0;
                end
                if (active) begin
                    vec[slot] = tx;
                    slot++;
                    if (slot == 40) begin
                        active = 1'b0;
                        if (tx_exp_q.size() == 0) begin
                            check("tx_unexpected_frame", {24'd0, vec}, 64'd0);
                        end else begin
                            exp = tx_exp_q.pop_front();
                            check("tx_frame", {24'd0, vec}, {24'd0, frame_bits(exp)});
                        end
                        tx_frames++;
                    end
                end
                prev_tx = tx;
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        int busy_cnt, early_done, early_irq;

        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        read_check("rst_stat", STAT, 32'h0);
        read_check("rst_rxd", RXD, 32'h0);

        // Transmit 0x55 with tx_ie set, polling STAT every cycle of the frame.
        bus_write(STAT, 32'h200);
        send_tx(8'h55);
        busy_cnt = 0; early_done = 0; early_irq = 0;
        for (int i = 0; i < 40; i++) begin
            if (irq === 1'b1) early_irq++;
            bus_read(STAT, d);
            if (d[1]) busy_cnt++;
            if (d[5]) early_done++;
        end
        check("tx_busy_cycles", busy_cnt, 40);
        check("tx_done_early", early_done, 0);
        check("tx_irq_early", early_irq, 0);
        check("tx_done_irq", irq, 1'b1);
        read_check("tx_done_stat", STAT, 32'h220);
        check("tx_frame_count_1", tx_frames, 1);
        bus_write(STAT, 32'h220);
        check("tx_w1c_irq", irq, 1'b0);
        read_check("tx_w1c_stat", STAT, 32'h200);

        // Write while busy: ignored, tx_err raised, frame keeps the first byte.
        send_tx(8'h3C);
        repeat (8) @(negedge clk);
        bus_write(TXD, 32'hA3);
        wait_tx_frames("tx_busy_frame_wait", 2);
        read_check("tx_err_stat", STAT, 32'h230);
        bus_write(STAT, 32'h030);
        read_check("tx_clear_stat", STAT, 32'h0);

        // Receive 0xC4 with rx_ie only.
        bus_write(STAT, 32'h100);
        send_rx(8'hC4, 1'b1);
        wait_irq("rx_irq_wait");
        @(negedge clk);
        check("rx_irq_hold", irq, 1'b1);
        read_rx_check("rx_byte_c4");
        check("rx_irq_clr", irq, 1'b0);
        read_check("rx_stat_after", STAT, 32'h100);

        // Two unread frames: overrun, newest byte kept.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (8) @(negedge clk);
        read_check("overrun_stat", STAT, 32'h109);
        read_rx_check("overrun_byte");
        bus_write(STAT, 32'h108);
        read_check("overrun_clr", STAT, 32'h100);

        // Stop bit sampled low: frame_err, byte still delivered.
        send_rx(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        read_check("frame_err_stat", STAT, 32'h105);
        read_rx_check("frame_err_byte");
        bus_write(STAT, 32'h104);
        read_check("frame_err_clr", STAT, 32'h100);

        // One-cycle low glitch must not produce a byte.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        read_check("glitch_stat", STAT, 32'h100);
        check("glitch_irq", irq, 1'b0);

        // Reset ten cycles into a frame, then transmit normally.
        send_tx(8'h81);
        repeat (10) @(negedge clk);
        check("mid_tx_low", tx, 1'b0);
        #2 reset = 1'b0;
        #1 check("mid_rst_tx", tx, 1'b1);
        @(negedge clk);
        read_check("mid_rst_stat", STAT, 32'h0);
        check("mid_rst_irq", irq, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        send_tx(8'h96);
        wait_tx_frames("post_rst_frame_wait", 3);
        read_check("post_rst_stat", STAT, 32'h20);
        check("tx_queue_empty", tx_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
